// File: rtl/counter_1bit_start1.sv
// Enable-gated up-counter that presets to START while Reset is low.
// With the default WIDTH=1/START=1 it acts as a toggle that comes out of reset high.
module counter_1bit_start1 #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned START = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Increase,
   output logic [WIDTH-1:0] Count
);

   // Reject illegal configurations at elaboration; 64-bit math keeps WIDTH=32 exact.
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "counter_1bit_start1: WIDTH=%0d outside 1..32", WIDTH);
   end
   if (64'(START) >= (64'd1 << WIDTH)) begin : g_bad_start
      $fatal(1, "counter_1bit_start1: START=%0d does not fit in WIDTH=%0d", START, WIDTH);
   end

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   // Increment wraps naturally at the register width.
   always_comb begin
      count_d = count_q;
      if (Increase) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         count_q <= WIDTH'(START);
      end else begin
         count_q <= count_d;
      end
   end

   assign Count = count_q;

endmodule

// File: tb/tb_counter_1bit_start1.sv
// Self-checking bench: default 1-bit/START=1 counter and a 3-bit/START=5 counter
// driven in parallel and compared against a modulo-arithmetic reference model.
module tb_counter_1bit_start1;

   logic       clk;
   logic       rst_n;
   logic       inc;
   logic [0:0] c1;
   logic [2:0] c3;

   int checks = 0;
   int errors = 0;

   // Reference model values (plain modular arithmetic).
   int m1;
   int m3;

   counter_1bit_start1 u_dut1 (
      .Clock   (clk),
      .Reset   (rst_n),
      .Increase(inc),
      .Count   (c1)
   );

   counter_1bit_start1 #(.WIDTH(3), .START(5)) u_dut3 (
      .Clock   (clk),
      .Reset   (rst_n),
      .Increase(inc),
      .Count   (c3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive Increase, cross one rising edge, update the model, settle 1ns past the edge.
   task automatic step(input logic i);
      inc = i;
      @(posedge clk);
      if (rst_n === 1'b1 && i) begin
         m1 = (m1 + 1) % 2;
         m3 = (m3 + 1) % 8;
      end
      #1;
   endtask

   task automatic model_reset();
      m1 = 1;
      m3 = 5;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      inc   = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (c1 !== 1'b1) begin errors++; $display("FAIL reset_async_w1: got %0d expected 1", c1); end
      checks++;
      if (c3 !== 3'd5) begin errors++; $display("FAIL reset_async_w3: got %0d expected 5", c3); end
      for (int k = 0; k < 4; k++) begin
         step(k[0]);
         checks++;
         if (c1 !== 1'b1) begin errors++; $display("FAIL reset_hold_w1: got %0d expected 1", c1); end
         checks++;
         if (c3 !== 3'd5) begin errors++; $display("FAIL reset_hold_w3: got %0d expected 5", c3); end
      end
   endtask

   task automatic test_toggle();
      logic [2:0] exp3 [4];
      exp3 = '{3'd6, 3'd7, 3'd0, 3'd1};
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1'b1);
         checks++;
         if (c1 !== 1'(k % 2)) begin errors++; $display("FAIL toggle_w1[%0d]: got %0d expected %0d", k, c1, k % 2); end
         checks++;
         if (c3 !== exp3[k]) begin errors++; $display("FAIL wrap_w3[%0d]: got %0d expected %0d", k, c3, exp3[k]); end
      end
   endtask

   task automatic test_hold();
      step(1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0);
         checks++;
         if (c1 !== 1'b0) begin errors++; $display("FAIL hold_w1[%0d]: got %0d expected 0", k, c1); end
         checks++;
         if (c3 !== 3'(m3)) begin errors++; $display("FAIL hold_w3[%0d]: got %0d expected %0d", k, c3, m3); end
      end
      step(1'b1);
      checks++;
      if (c1 !== 1'b1) begin errors++; $display("FAIL hold_release_w1: got %0d expected 1", c1); end
   endtask

   task automatic test_mid_reset();
      step(1'b1);
      checks++;
      if (c1 !== 1'b0) begin errors++; $display("FAIL mid_setup_w1: got %0d expected 0", c1); end
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (c1 !== 1'b1) begin errors++; $display("FAIL mid_async_w1: got %0d expected 1", c1); end
      checks++;
      if (c3 !== 3'd5) begin errors++; $display("FAIL mid_async_w3: got %0d expected 5", c3); end
      #4;
      rst_n = 1'b1;
      step(1'b0);
      checks++;
      if (c1 !== 1'b1) begin errors++; $display("FAIL mid_after_w1: got %0d expected 1", c1); end
      step(1'b1);
      checks++;
      if (c1 !== 1'b0) begin errors++; $display("FAIL mid_next_w1: got %0d expected 0", c1); end
      checks++;
      if (c3 !== 3'd6) begin errors++; $display("FAIL mid_next_w3: got %0d expected 6", c3); end
   endtask

   task automatic test_reset_priority();
      #2;
      rst_n = 1'b0;
      model_reset();
      step(1'b1);
      checks++;
      if (c1 !== 1'b1) begin errors++; $display("FAIL prio_w1: got %0d expected 1", c1); end
      checks++;
      if (c3 !== 3'd5) begin errors++; $display("FAIL prio_w3: got %0d expected 5", c3); end
      rst_n = 1'b1;
      step(1'b1);
      checks++;
      if (c1 !== 1'b0) begin errors++; $display("FAIL prio_release_w1: got %0d expected 0", c1); end
      checks++;
      if (c3 !== 3'd6) begin errors++; $display("FAIL prio_release_w3: got %0d expected 6", c3); end
   endtask

   task automatic test_wide();
      logic [2:0] exp3 [4];
      exp3 = '{3'd6, 3'd7, 3'd0, 3'd1};
      #2;
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1'b1);
         checks++;
         if (c3 !== exp3[k]) begin errors++; $display("FAIL wide_seq[%0d]: got %0d expected %0d", k, c3, exp3[k]); end
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (c3 !== 3'd5) begin errors++; $display("FAIL wide_reset: got %0d expected 5", c3); end
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            #($urandom_range(1, 5));
            rst_n = 1'b0;
            model_reset();
            #1;
            checks++;
            if (c3 !== 3'(m3)) begin errors++; $display("FAIL rand_async_w3[%0d]: got %0d expected %0d", n, c3, m3); end
            if ($urandom_range(0, 1) == 1) begin
               #1;
               rst_n = 1'b1;
            end
         end
         step(1'($urandom_range(0, 1)));
         rst_n = 1'b1;
         checks++;
         if (c1 !== 1'(m1)) begin errors++; $display("FAIL rand_w1[%0d]: got %0d expected %0d", n, c1, m1); end
         checks++;
         if (c3 !== 3'(m3)) begin errors++; $display("FAIL rand_w3[%0d]: got %0d expected %0d", n, c3, m3); end
      end
   endtask

   initial begin
      m1 = 0;
      m3 = 0;
      test_reset();
      test_toggle();
      test_hold();
      test_mid_reset();
      test_reset_priority();
      test_wide();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
